ad9767_dac_output_stage: RTL

Downstream stage between the two DDS waveform generators and the AD9767 dual 14-bit DAC pins.
- Per channel: gain scaling, signed DC offset and clamping of the offset-binary sample stream.
- Shared soft-mute/soft-start ramp for both channels.
- Generates the DAC CLK/WRT strobes from Clk, and aligns the Data bus to the opposite strobe edge for setup/hold margin.

---
 rtl/dds_dac_pkg.sv | 14 +
 rtl/dac_channel_datapath.sv | 102 ++++++++++
 rtl/ad9767_dac_output_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dds_dac_pkg.sv
// Shared constants and ramp FSM encoding for the AD9767 output stage.
package dds_dac_pkg;
    localparam int DW         = 14;
    localparam int MID        = 8192;
    localparam int UNITY_GAIN = 128;
    localparam int RAMP_MAX   = 256;

    typedef enum logic [1:0] {
        ST_MUTED   = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_UNMUTED = 2'd2,
        ST_RAMP_DN = 2'd3
    } ramp_state_e;
endpackage

// File: rtl/dac_channel_datapath.sv
// Per-channel gain, ramp scaling, DC offset and clamp of an offset-binary sample.
// Latency: 4 cycles from in_vld to out_vld.
// Backpressure: none; one sample per cycle is accepted and never stalled.
module dac_channel_datapath #(
    parameter int DW = dds_dac_pkg::DW
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 in_vld,
    input  logic [DW-1:0]        in_dat,
    input  logic [7:0]           gain,
    input  logic signed [14:0]   offset,
    input  logic [8:0]           ramp,
    output logic                 out_vld,
    output logic [DW-1:0]        out_dat,
    output logic                 sat
);
    import dds_dac_pkg::*;

    localparam int SW  = DW + 1;
    localparam int AW  = DW + 2;
    localparam int PGW = AW + 7;
    localparam int PRW = AW + 8;
    localparam int YW  = DW + 4;
    localparam logic signed [YW-1:0] MID_Y = YW'(MID);
    localparam logic signed [YW-1:0] MAX_Y = YW'((2 ** DW) - 1);

    logic                  s1_vld, s2_vld, s3_vld;
    logic signed [SW-1:0]  s1_s;
    logic [7:0]            s1_gain;
    logic signed [14:0]    s1_off, s2_off, s3_off;
    logic signed [AW-1:0]  s2_a, s3_b;

    logic signed [PGW-1:0] s_ext, g_ext, prod_g;
    logic signed [PRW-1:0] a_ext, r_ext, prod_r;
    logic signed [YW-1:0]  b_ext, off_ext, y;
    logic                  unused_bits;

    assign s_ext  = {{(PGW-SW){s1_s[SW-1]}}, s1_s};
    assign g_ext  = {{(PGW-8){1'b0}}, s1_gain};
    assign prod_g = s_ext * g_ext;

    assign a_ext  = {{(PRW-AW){s2_a[AW-1]}}, s2_a};
    assign r_ext  = {{(PRW-9){1'b0}}, ramp};
    assign prod_r = a_ext * r_ext;

    assign b_ext   = {{(YW-AW){s3_b[AW-1]}}, s3_b};
    assign off_ext = {{(YW-15){s3_off[14]}}, s3_off};
    assign y       = b_ext + off_ext + MID_Y;

    // Low product bits fall below the binary point and are dropped by the shifts.
    assign unused_bits = ^{prod_g[6:0], prod_r[7:0], prod_g[PGW-1], prod_r[PRW-1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            out_vld <= 1'b0;
            s1_s    <= '0;
            s1_gain <= '0;
            s1_off  <= '0;
            s2_off  <= '0;
            s3_off  <= '0;
            s2_a    <= '0;
            s3_b    <= '0;
            out_dat <= DW'(MID);
            sat     <= 1'b0;
        end else begin
            s1_vld  <= in_vld;
            s2_vld  <= s1_vld;
            s3_vld  <= s2_vld;
            out_vld <= s3_vld;
            if (in_vld) begin
                // Offset-binary to two's complement is an MSB flip.
                s1_s    <= {~in_dat[DW-1], ~in_dat[DW-1], in_dat[DW-2:0]};
                s1_gain <= gain;
                s1_off  <= offset;
            end
            if (s1_vld) begin
                s2_a   <= prod_g[AW+6:7];
                s2_off <= s1_off;
            end
            if (s2_vld) begin
                s3_b   <= prod_r[AW+7:8];
                s3_off <= s2_off;
            end
            sat <= 1'b0;
            if (s3_vld) begin
                if (y[YW-1]) begin
                    out_dat <= '0;
                    sat     <= 1'b1;
                end else if (y > MAX_Y) begin
                    out_dat <= MAX_Y[DW-1:0];
                    sat     <= 1'b1;
                end else begin
                    out_dat <= y[DW-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/ad9767_dac_output_stage.sv
// Two-channel DAC output stage: scaling, soft-mute ramp, AD9767 CLK/WRT strobes.
// Latency: 4 cycles to processed sample, then held until the next falling strobe.
// Backpressure: none; surplus samples within one DAC period are overwritten.
module ad9767_dac_output_stage #(
    parameter int DW       = dds_dac_pkg::DW,
    parameter int DIV      = 2,
    parameter int RAMP_DIV = 64
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 In_valid,
    input  logic [DW-1:0]        In_data1,
    input  logic [DW-1:0]        In_data2,
    input  logic [7:0]           Gain1,
    input  logic [7:0]           Gain2,
    input  logic signed [14:0]   Offset1,
    input  logic signed [14:0]   Offset2,
    input  logic                 Mute,
    output logic [DW-1:0]        Data1,
    output logic [DW-1:0]        Data2,
    output logic                 CLK1,
    output logic                 CLK2,
    output logic                 WRT1,
    output logic                 WRT2,
    output logic                 Muted,
    output logic                 Sat1,
    output logic                 Sat2
);
    import dds_dac_pkg::*;

    localparam int PW = $clog2(DIV);
    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
    localparam logic [TW-1:0] T_LAST = TW'(RAMP_DIV - 1);
    localparam logic [8:0]    R_MAX  = 9'(RAMP_MAX);
    localparam logic [DW-1:0] MID_D  = DW'(MID);

    logic [PW-1:0] phase, phase_nxt;
    logic          load, strobe;

    ramp_state_e   st, st_nxt;
    logic [8:0]    r, r_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          tick;

    logic          vld1, vld2;
    logic [DW-1:0] dat1, dat2, lat1, lat2;

    assign phase_nxt = (phase == P_LAST) ? '0 : phase + 1'b1;
    assign load      = (phase_nxt == P_HALF);
    assign tick      = (tmr == T_LAST);

    always_comb begin
        st_nxt  = st;
        r_nxt   = r;
        tmr_nxt = tmr;
        case (st)
            ST_MUTED: begin
                if (!Mute) st_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (r == R_MAX)  st_nxt = ST_UNMUTED;
                else if (Mute)   st_nxt = ST_RAMP_DN;
                else if (tick) begin
                    r_nxt   = r + 1'b1;
                    tmr_nxt = '0;
                end else         tmr_nxt = tmr + 1'b1;
            end
            ST_UNMUTED: begin
                if (Mute) st_nxt = ST_RAMP_DN;
            end
            ST_RAMP_DN: begin
                if (r == '0)     st_nxt = ST_MUTED;
                else if (!Mute)  st_nxt = ST_RAMP_UP;
                else if (tick) begin
                    r_nxt   = r - 1'b1;
                    tmr_nxt = '0;
                end else         tmr_nxt = tmr + 1'b1;
            end
            default: st_nxt = ST_MUTED;
        endcase
        // A direction change restarts the step interval from the current level.
        if (st_nxt != st) tmr_nxt = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            st  <= ST_MUTED;
            r   <= '0;
            tmr <= '0;
        end else begin
            st  <= st_nxt;
            r   <= r_nxt;
            tmr <= tmr_nxt;
        end
    end

    dac_channel_datapath #(.DW(DW)) u_ch1 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .in_vld  (In_valid),
        .in_dat  (In_data1),
        .gain    (Gain1),
        .offset  (Offset1),
        .ramp    (r),
        .out_vld (vld1),
        .out_dat (dat1),
        .sat     (Sat1)
    );

    dac_channel_datapath #(.DW(DW)) u_ch2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .in_vld  (In_valid),
        .in_dat  (In_data2),
        .gain    (Gain2),
        .offset  (Offset2),
        .ramp    (r),
        .out_vld (vld2),
        .out_dat (dat2),
        .sat     (Sat2)
    );

    // Data moves on the falling strobe so it is settled half a period before the rise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase  <= '0;
            strobe <= 1'b0;
            lat1   <= MID_D;
            lat2   <= MID_D;
            Data1  <= MID_D;
            Data2  <= MID_D;
        end else begin
            phase  <= phase_nxt;
            strobe <= (phase_nxt < P_HALF);
            if (vld1) lat1 <= dat1;
            if (vld2) lat2 <= dat2;
            if (load) begin
                Data1 <= vld1 ? dat1 : lat1;
                Data2 <= vld2 ? dat2 : lat2;
            end
        end
    end

    assign CLK1  = strobe;
    assign CLK2  = strobe;
    assign WRT1  = strobe;
    assign WRT2  = strobe;
    assign Muted = (st == ST_MUTED);
endmodule
